writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final stage of the 16-bit pipeline and the write end of the register-file interface that the decode stage reads.
- Holds the MEM/WB pipeline register and selects the load data or the ALU result.
- Drives RegWrite / write_register / write_Data into the decode stage's register file.
- Supplies same-cycle bypass hits for decode's two read ports, keeps load data stable across stalls, and counts retired instructions.

Parameters:
DATA_W, 16, datapath width
REG_AW, 3, register address width (8 registers)
CNT_W, 16, retired-instruction counter width
ZERO_REG_EN, 1, when 1, writes to register 0 are suppressed

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
stall  in  1  hold the MEM/WB register contents
flush  in  1  kill the instruction entering WB
in_valid  in  1  MEM stage holds a real instruction
in_RegWrite  in  1  instruction writes a register
in_MemtoReg  in  1  result comes from data memory
in_write_register  in  REG_AW  destination register, already RegDst-selected
in_alu_result  in  DATA_W  ALU result from MEM stage
mem_read_data  in  DATA_W  synchronous DMEM output; valid during the WB cycle only
rd_addr_1  in  REG_AW  decode read address, port 1
rd_addr_2  in  REG_AW  decode read address, port 2
RegWrite  out  1  register-file write enable
write_register  out  REG_AW  register-file write address
write_Data  out  DATA_W  register-file write data; also the bypass data
fwd_hit_1  out  1  write_Data must replace read_data_1
fwd_hit_2  out  1  write_Data must replace read_data_2
wb_valid  out  1  WB register holds a live instruction
retired_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (rst_n low, asynchronous): wb_valid=0, all stored fields=0, state=RUN, load_hold=0, retired_count=0. Consequently RegWrite=0, write_register=0, write_Data=0, fwd_hit_1=0, fwd_hit_2=0. Reset asserted mid-operation drops any in-flight write immediately, with no partial write.
- Capture (rising edge, stall=0):
  - wb_valid <= in_valid & ~flush.
  - RegWrite, MemtoReg, write_register and alu fields <= in_*.
  - Latency is one cycle from MEM to WB.
- stall=1: all stored fields hold. flush while stall=1: wb_valid cleared, other fields hold; flush takes priority over hold for the valid bit.
- Data state machine:
  - RUN: write_Data = MemtoReg ? mem_read_data : alu_result.
  - RUN -> HELD on an edge where stall=1, wb_valid=1 and MemtoReg=1. load_hold <= mem_read_data on that edge.
  - HELD: write_Data = MemtoReg ? load_hold : alu_result.
  - HELD -> RUN on the first edge with stall=0, or on flush or reset.
  - Non-load instructions never enter HELD.
- RegWrite = wb_valid & stored RegWrite & ~(ZERO_REG_EN & write_register==0). While stalled, RegWrite stays asserted with identical address and data every cycle; the repeated write is idempotent.
- fwd_hit_k = RegWrite & (rd_addr_k == write_register). This is purely combinational, because the register file updates at the edge and decode must see the value in the same cycle.
- retired_count increments on an edge where wb_valid=1 and stall=0, i.e. once per instruction regardless of stall length. An instruction with RegWrite=0 (store or branch) still counts. A flushed bubble does not count. Wraps from 2^CNT_W-1 to 0.
- Simultaneous stall and a load arriving in MEM: the MEM instruction is not captured, and the current WB contents are held.

Test Plan:
- Reset, then ALU op: in_valid=1, RegWrite=1, MemtoReg=0, reg=3, alu=16'h1234 -> next cycle RegWrite=1, write_register=3, write_Data=16'h1234, retired_count 0->1 at the following edge.
- Load with a 3-cycle stall: reg=5, MemtoReg=1, mem_read_data=16'hBEEF in the WB cycle, then mem_read_data changed to 16'h0000 while stall=1 -> write_Data stays 16'hBEEF for all 4 cycles; retired_count +1 only after stall drops.
- Zero register: RegWrite=1, reg=0, ZERO_REG_EN=1 -> RegWrite=0, fwd_hit_1=fwd_hit_2=0 with rd_addr_1=0; retired_count still +1.
- Bypass: WB writes reg 2 = 16'h00AA with rd_addr_1=2, rd_addr_2=4 -> fwd_hit_1=1, fwd_hit_2=0; the same op with RegWrite=0 gives both hits 0.
- Flush with stall: a live load held in WB, then flush=1 and stall=1 together -> wb_valid=0 and RegWrite=0 next cycle, state=RUN, count unchanged.
- Async reset mid-HELD: rst_n low between edges -> RegWrite drops immediately, retired_count=0; counter wrap checked with CNT_W=4 after 16 retirements -> 0.

Source files
------------

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final stage of the 16-bit pipeline. It holds the MEM/WB pipeline register,
// selects load data or the ALU result, and drives the write port of the
// register file that the decode stage reads. It also produces same-cycle
// bypass hits for decode's two read ports. A load's data is kept stable while
// the stage is stalled. Retired instructions are counted.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stall               hold the MEM/WB register contents
//   flush               kill the instruction entering WB (clears valid)
//   in_valid            MEM stage holds a real instruction
//   in_RegWrite         instruction writes a register
//   in_MemtoReg         result comes from data memory
//   in_write_register   destination register (already RegDst-selected)
//   in_alu_result       ALU result from the MEM stage
//   mem_read_data       synchronous DMEM output, valid during the WB cycle only
//   rd_addr_1/2         decode read addresses
//   RegWrite            register-file write enable
//   write_register      register-file write address
//   write_Data          register-file write data, also the bypass data
//   fwd_hit_1/2         write_Data must replace read_data_1/2 in decode
//   wb_valid            WB register holds a live instruction
//   retired_count       instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int CNT_W       = 16,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic [REG_AW-1:0] in_write_register,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [REG_AW-1:0] rd_addr_1,
    input  logic [REG_AW-1:0] rd_addr_2,
    output logic              RegWrite,
    output logic [REG_AW-1:0] write_register,
    output logic [DATA_W-1:0] write_Data,
    output logic              fwd_hit_1,
    output logic              fwd_hit_2,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retired_count
);

    // RUN: load data comes straight from DMEM.
    // HELD: DMEM output has moved on during a stall; use the captured copy.
    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } data_state_t;

    data_state_t       state, state_next;
    logic              wb_reg_write;
    logic              wb_memto_reg;
    logic [REG_AW-1:0] wb_write_register;
    logic [DATA_W-1:0] wb_alu_result;
    logic [DATA_W-1:0] load_hold;
    logic              is_zero_reg;
    logic              retire;

    // -------------------------------------------------------------------------
    // MEM/WB pipeline register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid          <= 1'b0;
            wb_reg_write      <= 1'b0;
            wb_memto_reg      <= 1'b0;
            wb_write_register <= '0;
            wb_alu_result     <= '0;
        end else if (stall) begin
            // Fields hold; a flush still kills the held instruction.
            if (flush) begin
                wb_valid <= 1'b0;
            end
        end else begin
            wb_valid          <= in_valid & ~flush;
            wb_reg_write      <= in_RegWrite;
            wb_memto_reg      <= in_MemtoReg;
            wb_write_register <= in_write_register;
            wb_alu_result     <= in_alu_result;
        end
    end

    // -------------------------------------------------------------------------
    // Load-data hold state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                // Only a live load that is about to stall needs its data kept;
                // a flush on the same edge kills it, so there is nothing to hold.
                if (stall && wb_valid && wb_memto_reg && !flush) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (!stall || flush) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Snapshot DMEM on the entry edge only; it stays put for the whole stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_hold <= '0;
        end else if (state == RUN && state_next == HELD) begin
            load_hold <= mem_read_data;
        end
    end

    // -------------------------------------------------------------------------
    // Register-file write port and bypass
    // -------------------------------------------------------------------------
    assign is_zero_reg    = (ZERO_REG_EN != 0) && (wb_write_register == '0);
    assign RegWrite       = wb_valid & wb_reg_write & ~is_zero_reg;
    assign write_register = wb_write_register;

    always_comb begin
        write_Data = wb_alu_result;
        if (wb_memto_reg) begin
            write_Data = (state == HELD) ? load_hold : mem_read_data;
        end
    end

    // Combinational on purpose: the register file only updates at the edge,
    // so decode must take write_Data in this same cycle.
    assign fwd_hit_1 = RegWrite & (rd_addr_1 == wb_write_register);
    assign fwd_hit_2 = RegWrite & (rd_addr_2 == wb_write_register);

    // -------------------------------------------------------------------------
    // Retired-instruction counter
    // -------------------------------------------------------------------------
    // An instruction leaves WB only on a non-stalled edge, so a long stall
    // still counts it once. Bubbles never count; stores/branches do.
    assign retire = wb_valid & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, in_valid, in_RegWrite, in_MemtoReg;
    logic [2:0]  in_write_register, rd_addr_1, rd_addr_2;
    logic [15:0] in_alu_result, mem_read_data;

    logic        RegWrite, fwd_hit_1, fwd_hit_2, wb_valid;
    logic [2:0]  write_register;
    logic [15:0] write_Data, retired_count;

    logic        s_RegWrite, s_fwd_hit_1, s_fwd_hit_2, s_wb_valid;
    logic [2:0]  s_write_register;
    logic [15:0] s_write_Data;
    logic [3:0]  s_retired_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
        .in_write_register(in_write_register), .in_alu_result(in_alu_result),
        .mem_read_data(mem_read_data), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .RegWrite(RegWrite), .write_register(write_register), .write_Data(write_Data),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .wb_valid(wb_valid),
        .retired_count(retired_count)
    );

    // Narrow-counter instance for the wrap check; shares all inputs.
    writeback_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
        .in_write_register(in_write_register), .in_alu_result(in_alu_result),
        .mem_read_data(mem_read_data), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .RegWrite(s_RegWrite), .write_register(s_write_register), .write_Data(s_write_Data),
        .fwd_hit_1(s_fwd_hit_1), .fwd_hit_2(s_fwd_hit_2), .wb_valid(s_wb_valid),
        .retired_count(s_retired_count)
    );

    typedef struct {
        logic        valid, rw, m2r, fl;
        logic [2:0]  wreg;
        logic [15:0] alu, mem;
        logic [2:0]  rd1, rd2;
        logic        e_rw;
        logic [2:0]  e_wr;
        logic [15:0] e_wd;
        logic        e_f1, e_f2, e_v;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic rw, input logic m2r,
                            input logic [2:0] wr, input logic [15:0] alu);
        in_valid          = v;
        in_RegWrite       = rw;
        in_MemtoReg       = m2r;
        in_write_register = wr;
        in_alu_result     = alu;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // valid rw m2r fl wreg alu mem rd1 rd2 | e_rw e_wr e_wd e_f1 e_f2 e_v e_cnt
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h0000, 3'd3, 3'd1,
                    1'b1, 3'd3, 16'h1234, 1'b1, 1'b0, 1'b1, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 16'h1111, 16'hBEEF, 3'd0, 3'd5,
                    1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h5555, 16'h0000, 3'd0, 3'd0,
                    1'b0, 3'd0, 16'h5555, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h00AA, 16'h0000, 3'd2, 3'd4,
                    1'b1, 3'd2, 16'h00AA, 1'b1, 1'b0, 1'b1, 16'd3};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h00AA, 16'h0000, 3'd2, 3'd4,
                    1'b0, 3'd2, 16'h00AA, 1'b0, 1'b0, 1'b1, 16'd4};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 16'h7777, 16'h0000, 3'd6, 3'd6,
                    1'b0, 3'd6, 16'h7777, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0001, 16'h0000, 3'd1, 3'd1,
                    1'b0, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 16'hFFFF, 16'h0000, 3'd7, 3'd7,
                    1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'd5};

        // ---------------- reset ----------------
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        mem_read_data = 16'h0; rd_addr_1 = 3'd0; rd_addr_2 = 3'd0;
        #22;
        check("rst_valid", wb_valid, 1'b0);
        check("rst_rw", RegWrite, 1'b0);
        check("rst_wr", write_register, 3'd0);
        check("rst_wd", write_Data, 16'h0);
        check("rst_fwd", {fwd_hit_1, fwd_hit_2}, 2'b00);
        check("rst_cnt", retired_count, 16'd0);
        rst_n = 1'b1;
        #2;

        // ---------------- table-driven single-cycle vectors ----------------
        for (int i = 0; i < 8; i++) begin
            drive_in(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].wreg, vecs[i].alu);
            flush = vecs[i].fl;
            tick();
            flush         = 1'b0;
            mem_read_data = vecs[i].mem;
            rd_addr_1     = vecs[i].rd1;
            rd_addr_2     = vecs[i].rd2;
            #1;
            check($sformatf("v%0d_rw", i), RegWrite, vecs[i].e_rw);
            check($sformatf("v%0d_wr", i), write_register, vecs[i].e_wr);
            check($sformatf("v%0d_wd", i), write_Data, vecs[i].e_wd);
            check($sformatf("v%0d_f1", i), fwd_hit_1, vecs[i].e_f1);
            check($sformatf("v%0d_f2", i), fwd_hit_2, vecs[i].e_f2);
            check($sformatf("v%0d_v", i), wb_valid, vecs[i].e_v);
            check($sformatf("v%0d_cnt", i), retired_count, vecs[i].e_cnt);
        end

        // ---------------- load with a 3-cycle stall ----------------
        drive_in(1'b1, 1'b1, 1'b1, 3'd5, 16'h2222);
        tick();
        mem_read_data = 16'hBEEF;
        #1;
        check("ld_wd0", write_Data, 16'hBEEF);
        check("ld_wr0", write_register, 3'd5);
        check("ld_cnt0", retired_count, 16'd6);
        // Another load waits in MEM while WB is stalled; it must not be taken.
        stall = 1'b1;
        drive_in(1'b1, 1'b1, 1'b1, 3'd4, 16'h3333);
        for (int k = 1; k <= 3; k++) begin
            tick();
            mem_read_data = 16'h0000;
            #1;
            check($sformatf("ld_wd%0d", k), write_Data, 16'hBEEF);
            check($sformatf("ld_wr%0d", k), write_register, 3'd5);
            check($sformatf("ld_rw%0d", k), RegWrite, 1'b1);
            check($sformatf("ld_cnt%0d", k), retired_count, 16'd6);
        end
        stall = 1'b0;
        tick();
        check("ld_next_wr", write_register, 3'd4);
        check("ld_cnt_after", retired_count, 16'd7);

        // ---------------- flush together with stall on a held load ----------------
        drive_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        mem_read_data = 16'hCAFE;
        stall = 1'b1;
        #1;
        check("fl_wd_run", write_Data, 16'hCAFE);
        tick();
        mem_read_data = 16'h0000;
        #1;
        check("fl_wd_held", write_Data, 16'hCAFE);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_read_data = 16'h1357;
        #1;
        check("fl_valid", wb_valid, 1'b0);
        check("fl_rw", RegWrite, 1'b0);
        check("fl_cnt", retired_count, 16'd7);
        check("fl_state_run", write_Data, 16'h1357);
        stall = 1'b0;

        // ---------------- async reset while HELD ----------------
        drive_in(1'b1, 1'b1, 1'b1, 3'd3, 16'h0);
        tick();
        mem_read_data = 16'hABCD;
        #1;
        check("ar_cnt_pre", retired_count, 16'd7);
        check("ar_wd_run", write_Data, 16'hABCD);
        stall = 1'b1;
        tick();
        mem_read_data = 16'h0000;
        #1;
        check("ar_wd_held", write_Data, 16'hABCD);
        check("ar_rw_pre", RegWrite, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rw", RegWrite, 1'b0);
        check("ar_valid", wb_valid, 1'b0);
        check("ar_cnt", retired_count, 16'd0);
        check("ar_wd", write_Data, 16'h0);
        stall = 1'b0;
        drive_in(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- counter wrap (CNT_W = 4 instance) ----------------
        drive_in(1'b1, 1'b1, 1'b0, 3'd1, 16'h0042);
        for (int k = 0; k < 16; k++) tick();
        check("wrap_small_15", s_retired_count, 4'd15);
        check("wrap_main_15", retired_count, 16'd15);
        tick();
        check("wrap_small_0", s_retired_count, 4'd0);
        check("wrap_main_16", retired_count, 16'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
